a5_1_stream_decryptor: RTL

- Receive-side counterpart of the team's A5/1 keystream encryptor. It contains its own A5/1 keystream core.
- Loads the shared 64-bit key, discards a warm-up run, then packs keystream bits into bytes.
- XORs each keystream byte with an incoming ciphertext pixel byte to recover the plaintext pixel.
- Sits between the ciphertext pixel source and the image sink. Uses valid/ready handshakes on both sides.

---
 rtl/a5_1_pkg.sv | 19 +
 rtl/a5_1_keystream_core.sv | 37 +++
 rtl/a5_1_stream_decryptor.sv | 128 ++++++++++++
 3 files changed

// File: rtl/a5_1_pkg.sv
// rtl/a5_1_pkg.sv - shared A5/1 constants and decryptor FSM state type
package a5_1_pkg;
  localparam int X_LEN = 19;
  localparam int Y_LEN = 22;
  localparam int Z_LEN = 23;
  localparam int X_CLK = 8;
  localparam int Y_CLK = 10;
  localparam int Z_CLK = 10;

  localparam logic [X_LEN-1:0] X_TAPS = 19'h72000;   // bits 18,17,16,13
  localparam logic [Y_LEN-1:0] Y_TAPS = 22'h300000;  // bits 21,20
  localparam logic [Z_LEN-1:0] Z_TAPS = 23'h700080;  // bits 22,21,20,7

  localparam int X_LO = 0;
  localparam int Y_LO = 19;
  localparam int Z_LO = 41;

  typedef enum logic [2:0] {IDLE, LOAD, WARM, GEN, WAIT_IN, WAIT_OUT} state_t;
endpackage

// File: rtl/a5_1_keystream_core.sv
// rtl/a5_1_keystream_core.sv - three majority-clocked LFSRs producing one keystream bit per step
module a5_1_keystream_core
  import a5_1_pkg::*;
(
  input  logic        clk,
  input  logic        load,
  input  logic [63:0] key,
  input  logic        step,
  output logic        ks_bit
);
  logic [X_LEN-1:0] x;
  logic [Y_LEN-1:0] y;
  logic [Z_LEN-1:0] z;
  logic maj, x_fb, y_fb, z_fb;

  always_comb begin
    maj  = (x[X_CLK] & y[Y_CLK]) | (x[X_CLK] & z[Z_CLK]) | (y[Y_CLK] & z[Z_CLK]);
    x_fb = ^(x & X_TAPS);
    y_fb = ^(y & Y_TAPS);
    z_fb = ^(z & Z_TAPS);
  end

  // Output bit is taken from the pre-shift register contents.
  assign ks_bit = x[X_LEN-1] ^ y[Y_LEN-1] ^ z[Z_LEN-1];

  always_ff @(posedge clk) begin
    if (load) begin
      x <= key[X_LO +: X_LEN];
      y <= key[Y_LO +: Y_LEN];
      z <= key[Z_LO +: Z_LEN];
    end else if (step) begin
      if (x[X_CLK] == maj) x <= {x[X_LEN-2:0], x_fb};
      if (y[Y_CLK] == maj) y <= {y[Y_LEN-2:0], y_fb};
      if (z[Z_CLK] == maj) z <= {z[Z_LEN-2:0], z_fb};
    end
  end
endmodule

// File: rtl/a5_1_stream_decryptor.sv
// rtl/a5_1_stream_decryptor.sv - A5/1 keystream XOR decryptor with valid/ready pixel streams
// Optional debug ports ks_dbg/ks_bit_dbg when A5_1_KS_DEBUG_EN is defined.
module a5_1_stream_decryptor
  import a5_1_pkg::*;
#(
  parameter int WARMUP    = 100,
  parameter int NUM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] key,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        busy,
  output logic        done
`ifdef A5_1_KS_DEBUG_EN
  ,
  output logic [7:0]  ks_dbg,
  output logic        ks_bit_dbg
`endif
);
  localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int BW = $clog2(NUM_BYTES + 1);

  state_t          state;
  logic [63:0]     key_q;
  logic [WW-1:0]   warm_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      ks_byte;
  logic [BW-1:0]   byte_cnt;
  logic            ks_bit;
  logic            core_load;
  logic            core_step;
  logic [63:0]     core_key;

  // Reset reuses the parallel load path with an all-zero key to clear the LFSRs.
  assign core_load = rst || (state == LOAD);
  assign core_key  = rst ? 64'd0 : key_q;
  assign core_step = (state == WARM) || (state == GEN);

  a5_1_keystream_core u_core (
    .clk    (clk),
    .load   (core_load),
    .key    (core_key),
    .step   (core_step),
    .ks_bit (ks_bit)
  );

`ifdef A5_1_KS_DEBUG_EN
  assign ks_dbg     = ks_byte;
  assign ks_bit_dbg = ks_bit;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      key_q    <= '0;
      warm_cnt <= '0;
      bit_cnt  <= '0;
      ks_byte  <= '0;
      byte_cnt <= '0;
      s_ready  <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        key_q    <= key;
        state    <= LOAD;
        busy     <= 1'b1;
        s_ready  <= 1'b0;
        m_valid  <= 1'b0;
        byte_cnt <= '0;
      end else begin
        case (state)
          IDLE: ;
          LOAD: begin
            warm_cnt <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            state    <= (WARMUP == 0) ? GEN : WARM;
          end
          WARM: begin
            warm_cnt <= warm_cnt + WW'(1);
            if (warm_cnt == WW'(WARMUP - 1)) state <= GEN;
          end
          GEN: begin
            ks_byte <= {ks_byte[6:0], ks_bit};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state   <= WAIT_IN;
              s_ready <= 1'b1;
            end
          end
          WAIT_IN: begin
            if (s_valid && s_ready) begin
              m_data  <= s_data ^ ks_byte;
              m_valid <= 1'b1;
              s_ready <= 1'b0;
              state   <= WAIT_OUT;
            end
          end
          WAIT_OUT: begin
            if (m_ready) begin
              m_valid  <= 1'b0;
              byte_cnt <= byte_cnt + BW'(1);
              if (byte_cnt == BW'(NUM_BYTES - 1)) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                state <= GEN;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
